// File: rtl/out_capture_fifo.sv
// Capture FIFO behind the upstream stage's output port.
// Registered storage, count-based full/empty and a sticky drop flag.
module out_capture_fifo #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Storage has no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A drop in the same cycle wins over a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/out_capture_fifo.md
OUT_CAPTURE_FIFO -- requirements
Module: out_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 20: width of each captured word, matching the upstream stage's PARAM2 output width.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries; power of two, 2 to 256.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  producer strobe; in_data is presented for capture this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  word from the upstream stage's out port.
REQ-007 SHALL have port out_valid  output  1  head word available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the head word.
REQ-009 SHALL have port out_data  output  DATA_W  head word; valid only while out_valid=1.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0 to DEPTH.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port empty  output  1  count==0.
REQ-013 SHALL have port overflow  output  1  sticky flag; a word was dropped.
REQ-014 SHALL have port clear_ovf  input  1  single-cycle request to clear overflow.

Function
REQ-015 SHALL define pop = out_valid & out_ready and push = in_valid & (~full | pop).
REQ-016 SHALL write in_data at the write pointer on push, then advance the pointer modulo DEPTH.
REQ-017 SHALL advance the read pointer modulo DEPTH on pop; the pointers wrap from DEPTH-1 to 0 with no gap.
REQ-018 SHALL drive out_valid = ~empty and out_data = mem[read pointer]; out_data is the registered storage read with no extra pipeline stage.
REQ-019 SHALL make a pushed word visible on out_valid/out_data on the cycle after the push edge (1-cycle latency); there is no bypass when empty.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-021 SHALL accept a push while full if a pop occurs in the same cycle; count stays DEPTH.
REQ-022 SHALL, when empty, treat out_ready as a no-op and leave pointers and count unchanged.
REQ-023 SHALL, when in_valid=1, full=1 and pop=0, discard in_data, leave storage unchanged, and set overflow on the next edge.
REQ-024 SHALL clear overflow on clear_ovf=1 unless a drop occurs the same cycle; the set takes priority.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL derive full and empty from count, not from pointer comparison alone, so that no full/empty aliasing occurs.

Reset
REQ-027 SHALL, when reset=1 at a clk edge, set pointers=0, count=0, empty=1, full=0, out_valid=0 and overflow=0; this reset takes priority over push, pop and clear_ovf.
REQ-028 SHALL, on reset mid-operation, discard all stored words; storage contents need not be cleared, and out_data is don't-care while empty.
REQ-029 SHALL ignore in_valid and out_ready during reset; operation resumes on the first edge with reset=0.

Verification
REQ-030 Reset then idle: hold reset 2 cycles, then release -> count=0, empty=1, out_valid=0, overflow=0.
REQ-031 Fill and drain, DEPTH=8: push 123,456,1..6 with out_ready=0 -> full=1, count=8; then out_ready=1 for 8 cycles -> out_data sequence 123,456,1..6, then empty=1.
REQ-032 Overflow: with the FIFO full and out_ready=0, push 999 -> overflow=1 next cycle, count=8, 999 never appears; pulse clear_ovf -> overflow=0.
REQ-033 Simultaneous at full: with count=8, in_valid=1 and out_ready=1 -> head popped, new word stored, count=8, overflow=0.
REQ-034 Wrap and streaming: 20 consecutive pushes with out_ready=1 -> outputs in order with 1-cycle latency, count never above 1, pointers wrap twice.
REQ-035 Reset mid-stream: with count=5, assert reset for 1 cycle together with in_valid=1 -> count=0, empty=1, and the concurrent word is not stored.
